// File: rtl/dp_pkg.sv
// dp_pkg: shared encodings and immediate generator for the multi-cycle datapath.
`default_nettype none

package dp_pkg;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_U = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MDR = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;
    localparam logic [1:0] c_WB_IMM = 2'd3;

    localparam logic [1:0] c_PC_PLUS4  = 2'd0;
    localparam logic [1:0] c_PC_IMM    = 2'd1;
    localparam logic [1:0] c_PC_BRANCH = 2'd2;
    localparam logic [1:0] c_PC_JALR   = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } state_e;

    // 32-bit sign-extended immediate; the caller widens it to XLEN.
    function automatic logic [31:0] imm_gen(input logic [31:0] ir, input logic [2:0] sel);
        logic [31:0] imm;
        case (sel)
            c_IMM_I: imm = {{20{ir[31]}}, ir[31:20]};
            c_IMM_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            c_IMM_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            c_IMM_U: imm = {ir[31:12], 12'b0};
            c_IMM_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU producing the result and {N,Z,C,V} flags.
`default_nettype none

module dp_alu
    import dp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic [3:0]      o_flags
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_sub;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_res;
    logic            w_c;
    logic            w_v;

    always_comb begin
        w_add   = {1'b0, i_a} + {1'b0, i_b};
        // Carry out of a + ~b + 1 is the not-borrow flag.
        w_sub   = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, 1'b1};
        w_shamt = i_b[SHW-1:0];
        w_c     = 1'b0;
        w_v     = 1'b0;
        case (i_op)
            c_ALU_ADD: begin
                w_res = w_add[XLEN-1:0];
                w_c   = w_add[XLEN];
                w_v   = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_res[XLEN-1] != i_a[XLEN-1]);
            end
            c_ALU_SUB: begin
                w_res = w_sub[XLEN-1:0];
                w_c   = w_sub[XLEN];
                w_v   = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_res[XLEN-1] != i_a[XLEN-1]);
            end
            c_ALU_AND:  w_res = i_a & i_b;
            c_ALU_OR:   w_res = i_a | i_b;
            c_ALU_XOR:  w_res = i_a ^ i_b;
            c_ALU_SLL:  w_res = i_a << w_shamt;
            c_ALU_SRL:  w_res = i_a >> w_shamt;
            c_ALU_SRA:  w_res = $signed(i_a) >>> w_shamt;
            c_ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            c_ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            default:    w_res = i_b;
        endcase
        o_result = w_res;
        o_flags  = {w_res[XLEN-1], (w_res == '0), w_c, w_v};
    end

endmodule

`default_nettype wire

// File: rtl/dp_multicycle.sv
// dp_multicycle: five-state multi-cycle datapath with a shared req/ready memory port.
`default_nettype none

module dp_multicycle
    import dp_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter int             NREG     = 32,
    parameter int             ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic [XLEN-1:0]   i_mem_rdata,
    input  logic              i_mem_ready,
    input  logic              i_reg_write,
    input  logic              i_alu_src,
    input  logic [3:0]        i_alu_op,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_wb_sel,
    input  logic [1:0]        i_pc_src,
    input  logic [2:0]        i_imm_sel,
    output logic [31:0]       o_inst_out,
    output logic [3:0]        o_status_flag,
    output logic [XLEN-1:0]   o_final_out,
    output logic [2:0]        o_state_out,
    output logic              o_retire
);

    localparam int IDX_W = $clog2(NREG);

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_a, r_b, r_imm, r_aluout, r_mdr;
    logic [3:0]        r_status;
    logic              r_mem_req, r_mem_we, r_retire;
    logic [XLEN-1:0]   r_rf [NREG];

    logic [IDX_W-1:0]  w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_imm, w_alu_b, w_alu_res, w_final;
    logic [3:0]        w_alu_flags;
    logic [ADDR_W-1:0] w_pc4, w_pc_imm, w_pc_next, w_addr_sel;

    assign w_rs1 = r_ir[15 +: IDX_W];
    assign w_rs2 = r_ir[20 +: IDX_W];
    assign w_rd  = r_ir[7 +: IDX_W];
    assign w_imm = XLEN'($signed(imm_gen(r_ir, i_imm_sel)));
    assign w_alu_b = i_alu_src ? r_imm : r_b;

    dp_alu #(.XLEN(XLEN)) u_alu (
        .i_op     (i_alu_op),
        .i_a      (r_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    always_comb begin
        w_pc4    = r_pc + ADDR_W'(4);
        w_pc_imm = r_pc + ADDR_W'(r_imm);
        case (i_pc_src)
            c_PC_PLUS4:  w_pc_next = w_pc4;
            c_PC_IMM:    w_pc_next = w_pc_imm;
            c_PC_BRANCH: w_pc_next = r_status[2] ? w_pc_imm : w_pc4;
            default:     w_pc_next = ADDR_W'(r_aluout) & ~ADDR_W'(1);
        endcase
        case (i_wb_sel)
            c_WB_ALU: w_final = r_aluout;
            c_WB_MDR: w_final = r_mdr;
            c_WB_PC4: w_final = XLEN'(w_pc4);
            default:  w_final = r_imm;
        endcase
        w_addr_sel = (r_state == ST_MEM) ? ADDR_W'(r_aluout) : r_pc;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_status  <= '0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_retire  <= 1'b0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    // Raises the request on the first cycle after reset; later fetches arrive with it set.
                    r_mem_req <= 1'b1;
                    if (r_mem_req && i_mem_ready) begin
                        r_ir      <= i_mem_rdata[31:0];
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_a     <= r_rf[w_rs1];
                    r_b     <= r_rf[w_rs2];
                    r_imm   <= w_imm;
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    r_aluout <= w_alu_res;
                    r_status <= w_alu_flags;
                    if (i_mem_read || i_mem_write) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= i_mem_write;
                        r_state   <= ST_MEM;
                    end else begin
                        r_retire <= 1'b1;
                        r_state  <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (i_mem_ready) begin
                        if (!r_mem_we) r_mdr <= i_mem_rdata;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_retire  <= 1'b1;
                        r_state   <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (i_reg_write && (w_rd != '0)) r_rf[w_rd] <= w_final;
                    r_pc      <= w_pc_next;
                    r_mem_req <= 1'b1;
                    r_state   <= ST_FETCH;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_FETCH;
                end
            endcase
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = {w_addr_sel[ADDR_W-1:2], 2'b00};
    assign o_mem_wdata   = r_b;
    assign o_inst_out    = r_ir;
    assign o_status_flag = r_status;
    assign o_final_out   = w_final;
    assign o_state_out   = r_state;
    assign o_retire      = r_retire;

endmodule

`default_nettype wire

// File: doc/dp_multicycle.md
Name: dp_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle datapath. It holds the PC, IR, register file, immediate generator, ALU and the A/B/ALUOut/MDR holding registers. A 5-state FSM sequences each instruction, and instruction fetch and data access share one external memory port with a req/ready handshake.
Control signals come from the external control unit, which decodes inst_out combinationally. The block samples them at its own state boundaries.

Parameters:
XLEN, 32, data/register width
NREG, 32, number of architectural registers (x0 hardwired zero); index width is clog2(NREG)
ADDR_W, 32, memory/PC address width (byte addresses)
RESET_PC, 0, PC value loaded at reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = write (store), 0 = read
mem_addr  out  ADDR_W  byte address, word aligned (low 2 bits forced 0)
mem_wdata  out  XLEN  store data (B register)
mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1
mem_ready  in  1  completes the current request
reg_write  in  1  write rd in WB
alu_src  in  1  0 = B register, 1 = immediate
alu_op  in  4  ALU function (package encoding)
mem_read  in  1  instruction loads
mem_write  in  1  instruction stores
wb_sel  in  2  0 = ALUOut, 1 = MDR, 2 = PC+4, 3 = immediate
pc_src  in  2  0 = PC+4, 1 = PC+imm, 2 = PC+imm if Z else PC+4, 3 = ALUOut & ~1
imm_sel  in  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J; others give 0
inst_out  out  32  current IR
status_flag  out  4  {N,Z,C,V}, registered in EXECUTE
final_out  out  XLEN  writeback data (combinational wb_sel mux)
state_out  out  3  current FSM state
retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; IR, A, B, ALUOut, MDR, status_flag and all registers = 0.
  - state=FETCH; mem_req=0; retire=0.
- States: FETCH -> DECODE -> EXECUTE -> (MEM if mem_read|mem_write) -> WB -> FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ready=1: IR<=mem_rdata, go to DECODE.
  - mem_ready low: stall indefinitely with mem_req and mem_addr held stable.
- DECODE:
  - A<=rf[rs1], B<=rf[rs2], IMM<=generated immediate. One cycle.
- EXECUTE:
  - ALUOut<=ALU(A, alu_src?IMM:B); status_flag updated.
  - Next state is MEM if mem_read|mem_write, else WB.
  - mem_read and mem_write both 1 is treated as a store.
- MEM:
  - mem_req=1, mem_addr=ALUOut, mem_we=mem_write, mem_wdata=B.
  - On mem_ready=1: MDR<=mem_rdata (loads only), go to WB.
- WB:
  - If reg_write and rd!=0: rf[rd]<=final_out.
  - PC updated per pc_src; the branch test uses the registered Z flag.
  - retire=1 for exactly this cycle; go to FETCH.
- Timing: 4 cycles per ALU/branch instruction and 5 per load/store, excluding memory wait cycles.
- ALU:
  - ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU; undefined codes pass operand B.
  - Shift amount is operand B[clog2(XLEN)-1:0].
  - C = carry-out of ADD or not-borrow of SUB; V = signed overflow of ADD/SUB, else 0.
  - Z = result==0; N = result MSB.
- Arithmetic: PC arithmetic wraps modulo 2^ADDR_W. Immediates are sign-extended to XLEN; U-type is imm<<12.
- Register file:
  - Reads are combinational.
  - A write and a read of the same register in the same cycle cannot occur, because of the state separation.
  - Writes to x0 are ignored and x0 always reads 0.
- Reset asserted mid-request: the transaction is abandoned and mem_req drops immediately. The memory side must tolerate this.
- mem_ready outside FETCH/MEM is ignored.

Decomposition:
- Package dp_pkg holds:
  - ALU opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4.
  - imm_sel, wb_sel and pc_src constants.
- Sub-module dp_alu (parametrised XLEN; combinational result plus flags) is natural. The register file and FSM stay inline.

Test Plan:
- Reset:
  - Release reset -> mem_req=1, mem_addr=0x0, state_out=FETCH.
  - Assert reset mid-FETCH -> mem_req=0 with no clock edge needed.
- Add immediate:
  - IR=ADDI x1,x0,5 (0x00500093), mem_ready=1 immediately, ctrl reg_write=1, alu_src=1, alu_op=ADD, imm_sel=I.
  - -> retire on cycle 4, x1=5, PC=4.
- Store/load:
  - Store 0x12345678 to address 0x10 -> mem_we=1, mem_addr=0x10, mem_wdata=0x12345678.
  - Load from 0x10 with rdata=0x12345678 -> rd=0x12345678, 5 cycles.
- Wait states:
  - Hold mem_ready=0 for 3 cycles in FETCH -> mem_req and mem_addr stable throughout; retire delayed by exactly 3.
- Branch:
  - BEQ with equal operands (SUB, Z=1), pc_src=2, imm=-8 at PC=0x20 -> PC=0x18.
  - Unequal operands -> PC=0x24.
- x0 and flags:
  - Write 7 to x0 -> x0 still reads 0.
  - ADD 0x7FFFFFFF+1 -> status_flag N=1, Z=0, C=0, V=1.
  - SUB 5-5 -> Z=1, C=1.
